// File: rtl/rob_pkg.sv
// Shared ROB definitions: default index width, entry kind encodings,
// per-entry static metadata and the redirect-PC helper.
package rob_pkg;

  localparam int ROB_BIT_DEF = 4;

  typedef enum logic [1:0] {
    ROB_KIND_REG    = 2'b00,
    ROB_KIND_BRANCH = 2'b01,
    ROB_KIND_STORE  = 2'b10,
    ROB_KIND_EXIT   = 2'b11
  } rob_kind_e;

  // Fields fixed at issue time; the result lives in a separate value array.
  typedef struct packed {
    rob_kind_e   kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] target;
    logic [31:0] fallthru;
  } rob_meta_t;

  function automatic logic [31:0] redirect_pc(input logic taken, input rob_meta_t m);
    return taken ? m.target : m.fallthru;
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// Combinational operand lookup for one decoder read port.
// ROB_WB_BYPASS_EN: also forwards this cycle's ALU/LSB broadcast (LSB wins).
module rob_lookup #(
  parameter int ROB_BIT = 4
) (
  input  logic [ROB_BIT-1:0] entry,
  input  logic               busy,
  input  logic               ready,
  input  logic [31:0]        value,
  input  logic               alu_ready,
  input  logic [ROB_BIT-1:0] alu_rob_entry,
  input  logic [31:0]        alu_value,
  input  logic               lsb_ready,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  output logic               q_ready,
  output logic [31:0]        q_value
);

`ifdef ROB_WB_BYPASS_EN
  // Registered state, overridden by a broadcast to a live entry this cycle
  always_comb begin
    q_ready = busy & ready;
    q_value = value;
    if (busy && lsb_ready && (lsb_rob_entry == entry)) begin
      q_ready = 1'b1;
      q_value = lsb_value;
    end else if (busy && alu_ready && (alu_rob_entry == entry)) begin
      q_ready = 1'b1;
      q_value = alu_value;
    end
  end
`else
  logic unused_bcast;
  assign unused_bcast = ^{entry, alu_ready, alu_rob_entry, alu_value,
                          lsb_ready, lsb_rob_entry, lsb_value};
  assign q_ready = busy & ready;
  assign q_value = value;
`endif

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular allocation, ALU/LSB writeback capture, in-order
// commit with branch resolution at head and a one-cycle flush pulse.
// Optional macro ROB_WB_BYPASS_EN adds same-cycle broadcast forwarding to lookups.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_signal,
  input  logic [1:0]         issue_kind,
  input  logic [4:0]         issue_rd,
  input  logic               issue_pred_taken,
  input  logic [31:0]        issue_target,
  input  logic [31:0]        issue_fallthru,
  output logic [ROB_BIT-1:0] tail_entry,
  output logic               is_full,
  input  logic               alu_ready,
  input  logic [ROB_BIT-1:0] alu_rob_entry,
  input  logic [31:0]        alu_value,
  input  logic               lsb_ready,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  input  logic [ROB_BIT-1:0] q1_entry,
  input  logic [ROB_BIT-1:0] q2_entry,
  output logic               q1_ready,
  output logic               q2_ready,
  output logic [31:0]        q1_value,
  output logic [31:0]        q2_value,
  output logic               commit_reg_en,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_value,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               store_commit_en,
  output logic [ROB_BIT-1:0] store_rob_entry,
  output logic               rob_clear_up,
  output logic [31:0]        new_pc,
  output logic               halt
);

  localparam int ROB_SIZE = 1 << ROB_BIT;

  logic [ROB_BIT-1:0]         head, tail;
  logic [ROB_BIT:0]           count;
  logic [ROB_SIZE-1:0]        busy, ready;
  logic [ROB_SIZE-1:0][31:0]  value;
  rob_meta_t                  meta [ROB_SIZE];

  rob_meta_t head_meta;
  logic      do_issue, do_commit, mispredict, actual_taken;

  assign tail_entry   = tail;
  assign is_full      = (count == (ROB_BIT+1)'(ROB_SIZE));
  assign head_meta    = meta[head];
  assign actual_taken = value[head][0];
  // rob_clear_up high marks the flush cycle: nothing enters or leaves
  assign do_issue     = issue_signal && !is_full && !rob_clear_up;
  assign do_commit    = (count != '0) && busy[head] && ready[head] && !halt && !rob_clear_up;
  assign mispredict   = do_commit && (head_meta.kind == ROB_KIND_BRANCH) &&
                        (actual_taken != head_meta.pred);

  // Entry array, pointers, occupancy and registered commit outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      value            <= '0;
      for (int i = 0; i < ROB_SIZE; i++) meta[i] <= '0;
      commit_reg_en    <= 1'b0;
      commit_rd        <= '0;
      commit_value     <= '0;
      commit_rob_entry <= '0;
      store_commit_en  <= 1'b0;
      store_rob_entry  <= '0;
      rob_clear_up     <= 1'b0;
      new_pc           <= '0;
      halt             <= 1'b0;
    end else if (rdy_in) begin
      commit_reg_en   <= 1'b0;
      store_commit_en <= 1'b0;
      rob_clear_up    <= 1'b0;
      if (!rob_clear_up) begin
        if (do_issue) begin
          busy[tail]          <= 1'b1;
          ready[tail]         <= 1'b0;
          meta[tail].kind     <= rob_kind_e'(issue_kind);
          meta[tail].rd       <= issue_rd;
          meta[tail].pred     <= issue_pred_taken;
          meta[tail].target   <= issue_target;
          meta[tail].fallthru <= issue_fallthru;
          tail                <= tail + ROB_BIT'(1);
        end
        // LSB written last so it wins an (illegal) same-entry collision
        if (alu_ready && busy[alu_rob_entry]) begin
          ready[alu_rob_entry] <= 1'b1;
          value[alu_rob_entry] <= alu_value;
        end
        if (lsb_ready && busy[lsb_rob_entry]) begin
          ready[lsb_rob_entry] <= 1'b1;
          value[lsb_rob_entry] <= lsb_value;
        end
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + ROB_BIT'(1);
          case (head_meta.kind)
            ROB_KIND_REG: begin
              commit_reg_en    <= 1'b1;
              commit_rd        <= head_meta.rd;
              commit_value     <= value[head];
              commit_rob_entry <= head;
            end
            ROB_KIND_STORE: begin
              store_commit_en <= 1'b1;
              store_rob_entry <= head;
            end
            ROB_KIND_EXIT: halt <= 1'b1;
            default: ;
          endcase
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + (ROB_BIT+1)'(1);
          2'b01:   count <= count - (ROB_BIT+1)'(1);
          default: ;
        endcase
        // Mispredict discards every younger entry, including one issued this edge
        if (mispredict) begin
          busy         <= '0;
          ready        <= '0;
          head         <= '0;
          tail         <= '0;
          count        <= '0;
          rob_clear_up <= 1'b1;
          new_pc       <= redirect_pc(actual_taken, head_meta);
        end
      end
    end
  end

  alu_lsb_same_entry: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(alu_ready && lsb_ready && (alu_rob_entry == lsb_rob_entry)));

  rob_lookup #(.ROB_BIT(ROB_BIT)) u_q1 (
    .entry(q1_entry), .busy(busy[q1_entry]), .ready(ready[q1_entry]), .value(value[q1_entry]),
    .alu_ready(alu_ready), .alu_rob_entry(alu_rob_entry), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .q_ready(q1_ready), .q_value(q1_value)
  );

  rob_lookup #(.ROB_BIT(ROB_BIT)) u_q2 (
    .entry(q2_entry), .busy(busy[q2_entry]), .ready(ready[q2_entry]), .value(value[q2_entry]),
    .alu_ready(alu_ready), .alu_rob_entry(alu_rob_entry), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .q_ready(q2_ready), .q_value(q2_value)
  );

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: stimulus pushes expected retirements, a negedge
// monitor pops and compares each commit/store/flush/halt event.
module tb_rob;

  localparam int EV_REG = 0, EV_STORE = 1, EV_CLEAR = 2, EV_HALT = 3;
  localparam logic [1:0] K_REG = 2'b00, K_BR = 2'b01, K_ST = 2'b10, K_EXIT = 2'b11;

  typedef struct {
    int          kind;
    int          rd;
    logic [31:0] val;
    int          entry;
    int          due;
  } ev_t;

  logic        clk = 0, rst_n = 1, rdy = 1;
  logic        issue_signal = 0, issue_pred_taken = 0;
  logic [1:0]  issue_kind = 0;
  logic [4:0]  issue_rd = 0;
  logic [31:0] issue_target = 0, issue_fallthru = 0;
  logic [3:0]  tail_entry;
  logic        is_full;
  logic        alu_ready = 0, lsb_ready = 0;
  logic [3:0]  alu_rob_entry = 0, lsb_rob_entry = 0, q1_entry = 0, q2_entry = 0;
  logic [31:0] alu_value = 0, lsb_value = 0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_reg_en, store_commit_en, rob_clear_up, halt;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, new_pc;
  logic [3:0]  commit_rob_entry, store_rob_entry;

  int  tests = 0, fails = 0, cyc = 0;
  logic rdy_seen = 0, halt_q = 0;
  ev_t exp_q[$];

  rob #(.ROB_BIT(4)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .issue_signal(issue_signal), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_target(issue_target), .issue_fallthru(issue_fallthru),
    .tail_entry(tail_entry), .is_full(is_full),
    .alu_ready(alu_ready), .alu_rob_entry(alu_rob_entry), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .q1_entry(q1_entry), .q2_entry(q2_entry), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_entry(commit_rob_entry), .store_commit_en(store_commit_en),
    .store_rob_entry(store_rob_entry), .rob_clear_up(rob_clear_up), .new_pc(new_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rdy_seen = rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int rd, input logic [31:0] val, input int entry, input int due);
    ev_t e;
    e.kind = kind; e.rd = rd; e.val = val; e.entry = entry; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int rd, input logic [31:0] val, input int entry);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d rd=%0d val=0x%0h entry=%0d at cyc %0d, expected none",
               kind, rd, val, entry, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.rd != rd || e.val !== val || e.entry != entry ||
          (e.due >= 0 && e.due != cyc)) begin
        fails++;
        $display("FAIL retire_event: got kind=%0d rd=%0d val=0x%0h entry=%0d cyc=%0d, expected kind=%0d rd=%0d val=0x%0h entry=%0d cyc=%0d",
                 kind, rd, val, entry, cyc, e.kind, e.rd, e.val, e.entry, e.due);
      end
    end
  endtask

  // Monitor: every retirement-side output pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (rst_n && rdy_seen) begin
      if (commit_reg_en)   got(EV_REG, int'(commit_rd), commit_value, int'(commit_rob_entry));
      if (store_commit_en) got(EV_STORE, 0, 32'h0, int'(store_rob_entry));
      if (rob_clear_up)    got(EV_CLEAR, 0, new_pc, 0);
      if (halt && !halt_q) got(EV_HALT, 0, 32'h0, 0);
    end
    halt_q = halt;
  end

  task automatic step();
    @(posedge clk); #1;
    issue_signal = 0; alu_ready = 0; lsb_ready = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_issue(input logic [1:0] k, input logic [4:0] rd, input logic p,
                           input logic [31:0] t, input logic [31:0] f);
    issue_signal = 1; issue_kind = k; issue_rd = rd;
    issue_pred_taken = p; issue_target = t; issue_fallthru = f;
  endtask

  task automatic alu_wb(input logic [3:0] e, input logic [31:0] v);
    alu_ready = 1; alu_rob_entry = e; alu_value = v;
  endtask

  task automatic lsb_wb(input logic [3:0] e, input logic [31:0] v);
    lsb_ready = 1; lsb_rob_entry = e; lsb_value = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_byp;
`ifdef ROB_WB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    // Reset
    #3 rst_n = 0;
    #4;
    chk("reset_tail", tail_entry, 0);
    chk("reset_full", is_full, 0);
    chk("reset_commit", commit_reg_en, 0);
    chk("reset_halt", halt, 0);
    chk("reset_q1_value", q1_value, 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    step();

    // REG rd=5, ALU wb 0x1234 -> commit one cycle after writeback
    set_issue(K_REG, 5, 0, 0, 0); step();
    alu_wb(0, 32'h1234); push_ev(EV_REG, 5, 32'h1234, 0, cyc + 2); step();
    idle(2);

    // Same-cycle lookup of entry 1 under ALU wb 0xAB
    set_issue(K_REG, 7, 0, 0, 0); step();
    q1_entry = 1; q2_entry = 1;
    alu_wb(1, 32'hAB); #1;
    chk("q1_bypass_ready", q1_ready, exp_byp);
    chk("q1_bypass_value", q1_value, exp_byp ? 32'hAB : 32'h0);
    push_ev(EV_REG, 7, 32'hAB, 1, cyc + 2); step();
    chk("q1_reg_ready", q1_ready, 1);
    chk("q2_reg_value", q2_value, 32'hAB);
    idle(2);

    // STORE at entry 2 retired via LSB completion
    set_issue(K_ST, 0, 0, 0, 0); step();
    lsb_wb(2, 32'hDEAD); push_ev(EV_STORE, 0, 32'h0, 2, cyc + 2); step();
    idle(2);

    // Out-of-order writeback: entry 4 first, entry 3 later; retire 3 then 4
    set_issue(K_REG, 1, 0, 0, 0); step();
    set_issue(K_REG, 2, 0, 0, 0); step();
    alu_wb(4, 32'h22); step();
    q2_entry = 4; #1;
    chk("q2_ooo_value", q2_value, 32'h22);
    idle(3);
    lsb_wb(3, 32'h11);
    push_ev(EV_REG, 1, 32'h11, 3, cyc + 2);
    push_ev(EV_REG, 2, 32'h22, 4, cyc + 3);
    step(); idle(3);

    // Correctly predicted branch retires silently, then a REG behind it
    set_issue(K_BR, 0, 1, 32'h200, 32'h44); step();
    alu_wb(5, 32'h1); step();
    set_issue(K_REG, 9, 0, 0, 0); step();
    alu_wb(6, 32'h99); push_ev(EV_REG, 9, 32'h99, 6, cyc + 2); step();
    idle(2);

    // Mispredict pred=0 actual=1 -> flush to target 0x100; wrong-path REG discarded
    set_issue(K_BR, 0, 0, 32'h100, 32'h80); step();
    set_issue(K_REG, 3, 0, 0, 0); step();
    lsb_wb(8, 32'h5); alu_wb(7, 32'h1); push_ev(EV_CLEAR, 0, 32'h100, 0, cyc + 2); step();
    step();
    chk("flush_tail", tail_entry, 0);
    set_issue(K_REG, 10, 0, 0, 0); step();
    chk("flush_issue_dropped", tail_entry, 0);
    chk("flush_not_full", is_full, 0);
    idle(3);

    // Mispredict pred=1 actual=0 -> redirect to fallthru
    set_issue(K_BR, 0, 1, 32'h300, 32'h64); step();
    alu_wb(0, 32'h0); push_ev(EV_CLEAR, 0, 32'h64, 0, cyc + 2); step();
    idle(3);

    // Fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      set_issue(K_REG, 5'(i + 1), 0, 0, 0); step();
    end
    chk("full_flag", is_full, 1);
    chk("full_tail_wrap", tail_entry, 0);
    set_issue(K_REG, 30, 0, 0, 0); step();
    chk("full_issue_ignored", tail_entry, 0);
    alu_wb(0, 32'h1000); set_issue(K_REG, 30, 0, 0, 0);
    push_ev(EV_REG, 1, 32'h1000, 0, cyc + 2); step();
    // Commit edge of entry 0: registered count still full, issue ignored
    alu_wb(1, 32'h1001); set_issue(K_REG, 30, 0, 0, 0);
    push_ev(EV_REG, 2, 32'h1001, 1, cyc + 2); step();
    chk("after_commit_not_full", is_full, 0);
    chk("after_commit_tail", tail_entry, 0);
    // Issue alongside entry 1 commit: occupancy unchanged at 15
    set_issue(K_REG, 20, 0, 0, 0); step();
    chk("issue_commit_tail", tail_entry, 1);
    chk("issue_commit_not_full", is_full, 0);
    set_issue(K_REG, 21, 0, 0, 0); step();
    chk("refill_full", is_full, 1);
    chk("refill_tail", tail_entry, 2);

    // Asynchronous reset mid-run with the buffer busy
    q1_entry = 5; #2;
    rst_n = 0; #1;
    chk("midreset_tail", tail_entry, 0);
    chk("midreset_full", is_full, 0);
    chk("midreset_q1_ready", q1_ready, 0);
    chk("midreset_commit", commit_reg_en, 0);
    @(negedge clk); rst_n = 1;
    step();

    // Pause: rdy low freezes a pending commit and drops issue
    set_issue(K_REG, 4, 0, 0, 0); step();
    alu_wb(0, 32'h44); step();
    rdy = 0; set_issue(K_REG, 11, 0, 0, 0);
    idle(3);
    chk("pause_no_commit", commit_reg_en, 0);
    chk("pause_tail", tail_entry, 1);
    rdy = 1; push_ev(EV_REG, 4, 32'h44, 0, cyc + 1);
    step(); idle(2);

    // EXIT: halt sticky, nothing retires after it
    set_issue(K_EXIT, 0, 0, 0, 0); step();
    lsb_wb(1, 32'h0); push_ev(EV_HALT, 0, 32'h0, 0, cyc + 2); step();
    idle(2);
    chk("halt_set", halt, 1);
    set_issue(K_REG, 6, 0, 0, 0); step();
    alu_wb(2, 32'h66); step();
    idle(3);
    chk("halt_sticky", halt, 1);
    chk("halt_tail", tail_entry, 3);

    idle(2);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
